// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared constants, state encoding and address-check helper
//                for the two-port data-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    localparam int WORD_W        = 32;
    localparam int DEFAULT_DEPTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_G0   = 2'd1;
    localparam logic [1:0] ST_G1   = 2'd2;

    // An access is rejected when misaligned or beyond the last word.
    function automatic logic addr_is_bad(input logic [WORD_W-1:0] addr,
                                         input int unsigned       depth);
        logic [WORD_W+1:0] limit;
        limit = {2'b00, depth} << 2;
        return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port arbiter in front of a single-port data memory.
//                Round-robin on ties, with a cap on port-1 bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int P1_MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              resetn,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [WORD_W-1:0] p0_addr,
    input  logic [WORD_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_stall,
    output logic              p0_err,
    output logic [WORD_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [WORD_W-1:0] p1_addr,
    input  logic [WORD_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_stall,
    output logic              p1_err,
    output logic [WORD_W-1:0] p1_rdata,

    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam int                 BURST_W   = (P1_MAX_BURST < 1) ? 1 : $clog2(P1_MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(P1_MAX_BURST);

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic               last_p1;
    logic               last_next;
    logic [BURST_W-1:0] burst;
    logic [BURST_W-1:0] burst_next;
    logic               p1_capped;

    logic               sel_we;
    logic [WORD_W-1:0]  sel_addr;
    logic [WORD_W-1:0]  sel_wdata;
    logic               granted;
    logic               bad;
    logic               access;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            last_p1 <= 1'b1;
            burst   <= '0;
        end else begin
            state   <= state_next;
            last_p1 <= last_next;
            burst   <= burst_next;
        end
    end

    // The cap is judged on the burst count including the cycle now ending,
    // so a p0 grant always resets the budget before the next tie.
    always_comb begin
        burst_next = '0;
        if (state == ST_G1) begin
            burst_next = burst;
            if (p0_req && (burst != BURST_MAX)) begin
                burst_next = burst + 1'b1;
            end
        end
        p1_capped = (burst_next == BURST_MAX);

        case ({p0_req, p1_req})
            2'b10:   state_next = ST_G0;
            2'b01:   state_next = ST_G1;
            2'b11:   state_next = (last_p1 || p1_capped) ? ST_G0 : ST_G1;
            default: state_next = ST_IDLE;
        endcase

        // The pointer names the port holding the grant now being issued.
        last_next = last_p1;
        if (state_next == ST_G0) begin
            last_next = 1'b0;
        end else if (state_next == ST_G1) begin
            last_next = 1'b1;
        end
    end

    always_comb begin
        p0_gnt    = (state == ST_G0);
        p1_gnt    = (state == ST_G1);
        granted   = p0_gnt || p1_gnt;

        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (p0_gnt) begin
            sel_we    = p0_we;
            sel_addr  = p0_addr;
            sel_wdata = p0_wdata;
        end else if (p1_gnt) begin
            sel_we    = p1_we;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end

        bad       = granted && addr_is_bad(sel_addr, DEPTH);
        access    = granted && !bad;

        mem_addr  = sel_addr;
        mem_wdata = sel_wdata;
        mem_we    = access && sel_we;
        mem_re    = access && !sel_we;

        p0_err    = p0_gnt && bad;
        p1_err    = p1_gnt && bad;
        p0_rdata  = (p0_gnt && mem_re) ? mem_rdata : '0;
        p1_rdata  = (p1_gnt && mem_re) ? mem_rdata : '0;

        p0_stall  = p0_req && !p0_gnt;
        p1_stall  = p1_req && !p1_gnt;
    end

    a_one_grant : assert property (@(posedge clock) disable iff (!resetn)
        !(p0_gnt && p1_gnt));
    a_one_strobe : assert property (@(posedge clock) disable iff (!resetn)
        !(mem_we && mem_re));
    a_err_no_access : assert property (@(posedge clock) disable iff (!resetn)
        (p0_err || p1_err) |-> !(mem_we || mem_re));

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed and randomized bench for dmem_arbiter with a
//                grant/memory reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int DEPTH        = 32;
    localparam int P1_MAX_BURST = 4;
    localparam int AW           = $clog2(DEPTH);

    logic        clock = 1'b0;
    logic        resetn;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_stall, p0_err, p1_gnt, p1_stall, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;

    int vectors     = 0;
    int miscompares = 0;

    dmem_arbiter #(.DEPTH(DEPTH), .P1_MAX_BURST(P1_MAX_BURST)) dut (
        .clock(clock), .resetn(resetn),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_stall(p0_stall), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_stall(p1_stall), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Data memory seen by the arbiter: combinational read, write on negedge.
    logic [31:0] mem [0:DEPTH-1] = '{default: '0};
    assign mem_rdata = mem[mem_addr[AW+1:2]];
    always @(negedge clock) begin
        if (mem_we) mem[mem_addr[AW+1:2]] = mem_wdata;
    end

    // Reference model: who owns the current cycle, and what memory holds.
    int          m_g;     // 0 = nobody, 1 = port 0, 2 = port 1
    int          m_last;  // port that received the most recent grant
    int          m_run;   // port-1 grants in a row while port 0 was waiting
    int          m_nxt;
    logic [31:0] ref_mem [0:DEPTH-1] = '{default: '0};

    function automatic bit ref_bad(logic [31:0] a);
        return ((a % 32'd4) != 0) || (longint'(a) >= longint'(4 * DEPTH));
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_g = 0; m_last = 2; m_run = 0;
        end else begin
            if (m_g == 2) begin
                if (p0_req && m_run < P1_MAX_BURST) m_run = m_run + 1;
            end else begin
                m_run = 0;
            end
            if (p0_req && p1_req)  m_nxt = (m_last == 2 || m_run >= P1_MAX_BURST) ? 1 : 2;
            else if (p0_req)       m_nxt = 1;
            else if (p1_req)       m_nxt = 2;
            else                   m_nxt = 0;
            if (m_nxt != 0) m_last = m_nxt;
            m_g = m_nxt;
        end
    end

    always @(negedge clock) begin
        if (m_g == 1 && p0_we && !ref_bad(p0_addr)) ref_mem[p0_addr[AW+1:2]] = p0_wdata;
        if (m_g == 2 && p1_we && !ref_bad(p1_addr)) ref_mem[p1_addr[AW+1:2]] = p1_wdata;
    end

    task automatic to_drive; @(negedge clock); #1; endtask
    task automatic to_check; @(posedge clock); #1; endtask

    task automatic idle_inputs;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic do_reset;
        to_drive; resetn = 0; idle_inputs;
        to_check;
        to_drive; resetn = 1;
    endtask

    task automatic test_reset;
        to_drive; resetn = 0; p0_req = 1; p0_we = 1; p0_addr = 32'h8; p0_wdata = 32'h1;
        to_check;
        vectors++;
        if ({p0_gnt, p1_gnt, p0_err, p1_err, mem_we, mem_re, p0_stall, p1_stall} !== 8'b0000_0010) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b expected %b",
                     {p0_gnt, p1_gnt, p0_err, p1_err, mem_we, mem_re, p0_stall, p1_stall}, 8'b0000_0010);
        end
        vectors++;
        if ({mem_addr, mem_wdata, p0_rdata, p1_rdata} !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_buses: got %h expected 0", {mem_addr, mem_wdata, p0_rdata, p1_rdata});
        end
        to_drive; idle_inputs; resetn = 1;
    endtask

    task automatic test_p0_write;
        do_reset;
        to_drive; p0_req = 1; p0_we = 1; p0_addr = 32'h8; p0_wdata = 32'hDEADBEEF;
        #1;
        vectors++;
        if ({p0_stall, p0_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL p0wr_wait: got stall,gnt=%b expected 10", {p0_stall, p0_gnt});
        end
        to_check;
        vectors++;
        if ({p0_gnt, p0_stall, mem_we, mem_re} !== 4'b1010) begin
            miscompares++;
            $display("FAIL p0wr_grant: got gnt,stall,we,re=%b expected 1010", {p0_gnt, p0_stall, mem_we, mem_re});
        end
        vectors++;
        if (mem_addr !== 32'h8 || mem_wdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL p0wr_bus: got addr=%h data=%h expected 00000008 deadbeef", mem_addr, mem_wdata);
        end
        to_drive; p0_req = 0;
        to_check;
        vectors++;
        if ({p0_gnt, p0_stall, mem_we} !== 3'b000) begin
            miscompares++;
            $display("FAIL p0wr_after: got gnt,stall,we=%b expected 000", {p0_gnt, p0_stall, mem_we});
        end
        vectors++;
        if (mem[2] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL p0wr_stored: got %h expected deadbeef", mem[2]);
        end
        to_drive; idle_inputs;
    endtask

    task automatic test_alternate;
        do_reset;
        to_drive; p0_req = 1; p0_addr = 32'h0; p1_req = 1; p1_addr = 32'h4;
        for (int i = 0; i < 6; i++) begin
            logic [1:0] exp_g;
            to_check;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            vectors++;
            if ({p1_gnt, p0_gnt} !== exp_g) begin
                miscompares++;
                $display("FAIL alternate[%0d]: got p1,p0 gnt=%b expected %b", i, {p1_gnt, p0_gnt}, exp_g);
            end
        end
        to_drive; idle_inputs;
    endtask

    task automatic test_p1_burst;
        do_reset;
        to_drive; p1_req = 1; p1_addr = 32'hC;
        for (int i = 0; i < 4; i++) begin
            to_check;
            vectors++;
            if ({p1_gnt, p0_gnt} !== 2'b10) begin
                miscompares++;
                $display("FAIL p1_solo[%0d]: got p1,p0 gnt=%b expected 10", i, {p1_gnt, p0_gnt});
            end
        end
        to_drive; p0_req = 1; p0_addr = 32'h8;
        for (int i = 0; i < 6; i++) begin
            logic [1:0] exp_g;
            to_check;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            vectors++;
            if ({p1_gnt, p0_gnt} !== exp_g) begin
                miscompares++;
                $display("FAIL p1_then_both[%0d]: got p1,p0 gnt=%b expected %b", i, {p1_gnt, p0_gnt}, exp_g);
            end
        end
        to_drive; idle_inputs;
    endtask

    task automatic test_bad_addr;
        logic [31:0] addrs [3] = '{32'h6, 32'h80, 32'h7C};
        do_reset;
        for (int i = 0; i < 3; i++) begin
            bit          e_bad;
            logic [31:0] e_rd;
            e_bad = (i != 2);
            e_rd  = e_bad ? 32'h0 : ref_mem[DEPTH-1];
            to_drive; p1_req = 1; p1_we = 0; p1_addr = addrs[i];
            to_check;
            vectors++;
            if ({p1_gnt, p1_err, mem_re, mem_we} !== {1'b1, e_bad, !e_bad, 1'b0}) begin
                miscompares++;
                $display("FAIL badaddr_ctl[%h]: got gnt,err,re,we=%b expected %b",
                         addrs[i], {p1_gnt, p1_err, mem_re, mem_we}, {1'b1, e_bad, !e_bad, 1'b0});
            end
            vectors++;
            if (p1_rdata !== e_rd) begin
                miscompares++;
                $display("FAIL badaddr_rdata[%h]: got %h expected %h", addrs[i], p1_rdata, e_rd);
            end
            to_drive; p1_req = 0;
            to_check;
            vectors++;
            if ({p1_gnt, p1_err} !== 2'b00) begin
                miscompares++;
                $display("FAIL badaddr_pulse[%h]: got gnt,err=%b expected 00", addrs[i], {p1_gnt, p1_err});
            end
        end
        to_drive; idle_inputs;
    endtask

    task automatic test_reset_mid_grant;
        do_reset;
        to_drive; p0_req = 1; p0_we = 1; p0_addr = 32'h14; p0_wdata = 32'hA5A50F0F;
        to_check;
        vectors++;
        if ({p0_gnt, mem_we} !== 2'b11) begin
            miscompares++;
            $display("FAIL rstmid_grant: got gnt,we=%b expected 11", {p0_gnt, mem_we});
        end
        #1 resetn = 0;
        #1;
        vectors++;
        if ({p0_gnt, mem_we, p0_stall} !== 3'b001) begin
            miscompares++;
            $display("FAIL rstmid_abort: got gnt,we,stall=%b expected 001", {p0_gnt, mem_we, p0_stall});
        end
        to_drive; resetn = 1;
        vectors++;
        if (mem[5] !== 32'h0) begin
            miscompares++;
            $display("FAIL rstmid_nowrite: got %h expected 00000000", mem[5]);
        end
        to_check;
        vectors++;
        if ({p0_gnt, mem_we} !== 2'b11) begin
            miscompares++;
            $display("FAIL rstmid_regrant: got gnt,we=%b expected 11", {p0_gnt, mem_we});
        end
        to_drive; p0_req = 0;
        vectors++;
        if (mem[5] !== 32'hA5A50F0F) begin
            miscompares++;
            $display("FAIL rstmid_written: got %h expected a5a50f0f", mem[5]);
        end
        idle_inputs;
    endtask

    task automatic test_write_read;
        do_reset;
        to_drive; p1_req = 1; p1_we = 1; p1_addr = 32'h10; p1_wdata = 32'h12345678;
        to_check;
        vectors++;
        if ({p1_gnt, mem_we} !== 2'b11) begin
            miscompares++;
            $display("FAIL wr_rd_write: got gnt,we=%b expected 11", {p1_gnt, mem_we});
        end
        to_drive; p1_req = 0; p1_we = 0; p0_req = 1; p0_we = 0; p0_addr = 32'h10;
        to_check;
        vectors++;
        if ({p0_gnt, mem_re} !== 2'b11 || p0_rdata !== 32'h12345678) begin
            miscompares++;
            $display("FAIL wr_rd_read: got gnt,re=%b rdata=%h expected 11 12345678", {p0_gnt, mem_re}, p0_rdata);
        end
        to_drive; idle_inputs;
    endtask

    task automatic pick_txn(output logic req, output logic we,
                            output logic [31:0] addr, output logic [31:0] wdata);
        int unsigned r;
        req = ($urandom_range(0, 3) != 0);
        we  = 1'($urandom_range(0, 1));
        r   = $urandom_range(0, 9);
        if (r == 0)      addr = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        else if (r == 1) addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 63)) * 4;
        else             addr = 32'($urandom_range(0, 7)) * 4;
        wdata = $urandom;
    endtask

    task automatic test_random;
        bit          e_g0, e_g1, e_bad, e_we;
        logic [7:0]  e_ctl;
        logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
        do_reset;
        for (int cyc = 0; cyc < 400; cyc++) begin
            to_drive;
            if (m_g == 1 || !p0_req)              pick_txn(p0_req, p0_we, p0_addr, p0_wdata);
            else if ($urandom_range(0, 15) == 0)  p0_req = 0;
            if (m_g == 2 || !p1_req)              pick_txn(p1_req, p1_we, p1_addr, p1_wdata);
            else if ($urandom_range(0, 15) == 0)  p1_req = 0;
            to_check;
            e_g0    = (m_g == 1);
            e_g1    = (m_g == 2);
            e_bad   = e_g0 ? ref_bad(p0_addr) : (e_g1 ? ref_bad(p1_addr) : 1'b0);
            e_we    = e_g0 ? p0_we : (e_g1 ? p1_we : 1'b0);
            e_addr  = e_g0 ? p0_addr : (e_g1 ? p1_addr : 32'h0);
            e_wdata = e_g0 ? p0_wdata : (e_g1 ? p1_wdata : 32'h0);
            e_rd0   = (e_g0 && !e_bad && !p0_we) ? ref_mem[p0_addr[AW+1:2]] : 32'h0;
            e_rd1   = (e_g1 && !e_bad && !p1_we) ? ref_mem[p1_addr[AW+1:2]] : 32'h0;
            e_ctl   = {e_g0, e_g1, p0_req && !e_g0, p1_req && !e_g1, e_g0 && e_bad, e_g1 && e_bad,
                       (e_g0 || e_g1) && !e_bad && e_we, (e_g0 || e_g1) && !e_bad && !e_we};
            vectors++;
            if ({p0_gnt, p1_gnt, p0_stall, p1_stall, p0_err, p1_err, mem_we, mem_re} !== e_ctl) begin
                miscompares++;
                $display("FAIL rand_ctl[%0d]: got %b expected %b", cyc,
                         {p0_gnt, p1_gnt, p0_stall, p1_stall, p0_err, p1_err, mem_we, mem_re}, e_ctl);
            end
            vectors++;
            if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin
                miscompares++;
                $display("FAIL rand_bus[%0d]: got %h/%h expected %h/%h", cyc, mem_addr, mem_wdata, e_addr, e_wdata);
            end
            vectors++;
            if (p0_rdata !== e_rd0 || p1_rdata !== e_rd1) begin
                miscompares++;
                $display("FAIL rand_rdata[%0d]: got %h/%h expected %h/%h", cyc, p0_rdata, p1_rdata, e_rd0, e_rd1);
            end
        end
        to_drive; idle_inputs;
    endtask

    initial begin
        resetn = 0;
        idle_inputs;
        test_reset;
        test_p0_write;
        test_alternate;
        test_p1_burst;
        test_bad_addr;
        test_reset_mid_grant;
        test_write_read;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
